fc_layer_engine: RTL and testbench

Parametrised, time-multiplexed fully-connected layer engine for the BiLSTM localisation head. It replaces the fixed FC1/FC2 instances with a single reusable block. Each instance computes `out = sat(round(W·x + b))` in Q4.12 using K parallel MAC lanes that share one sequencer. Weights and biases are read from external single-port memories with 1-cycle latency. Instances chain through `start`/`done` to form the 200→100→3 head or any other depth.

---
 rtl/fc_pkg.sv | 40 ++++
 rtl/fc_mac_lane.sv | 40 ++++
 rtl/fc_layer_engine.sv | 170 +++++++++++++++++
 tb/tb_fc_layer_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared state type and Q-format helpers for fc_layer_engine.
// Fused ReLU in the engine is selected by the FC_RELU_EN macro.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WB,
        S_DONE
    } fc_state_t;

    localparam logic signed [15:0] FC_QMAX = 16'sh7FFF;
    localparam logic signed [15:0] FC_QMIN = 16'sh8000;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Round half up, drop the fraction, then clamp to the signed output range.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int                 frac_bits,
        input int                 data_width
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_width - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one signed multiply-accumulate lane with
// synchronous clear (priority) and enable; accumulator wraps.
module fc_mac_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_d;

    always_comb begin
        prod  = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: time-multiplexed FC layer, K lanes per output group.
// Define FC_RELU_EN to clamp writeback results to >= 0 (fused ReLU).
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int FRAC_BITS  = 12,
    parameter int IN_DIM     = 200,
    parameter int OUT_DIM    = 100,
    parameter int K          = 4,
    localparam int G  = ceil_div(OUT_DIM, K),
    localparam int AW = (G * IN_DIM > 1) ? $clog2(G * IN_DIM) : 1,
    localparam int BW = (G > 1) ? $clog2(G) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [IN_DIM*DATA_WIDTH-1:0]  in_vector,
    output logic [AW-1:0]                 w_addr,
    input  logic [K*DATA_WIDTH-1:0]       w_data,
    output logic [BW-1:0]                 b_addr,
    input  logic [K*DATA_WIDTH-1:0]       b_data,
    output logic [OUT_DIM*DATA_WIDTH-1:0] out_vector,
    output logic                          busy,
    output logic                          done
);

    localparam int IW = $clog2(IN_DIM + 1);

    fc_state_t                     state_q;
    logic [BW-1:0]                 g_q;
    logic [IW-1:0]                 i_q;
    logic [AW-1:0]                 w_addr_q;
    logic                          busy_q;
    logic                          done_q;
    logic [IN_DIM*DATA_WIDTH-1:0]  x_q;
    logic [K*DATA_WIDTH-1:0]       bias_q;
    logic [OUT_DIM*DATA_WIDTH-1:0] out_q;
    logic [OUT_DIM*DATA_WIDTH-1:0] out_d;

    logic                          accept;
    logic                          last_grp;
    logic                          lane_clr;
    logic                          lane_en;
    logic [IW-1:0]                 xi;
    logic signed [DATA_WIDTH-1:0]  x_op;
    logic signed [ACC_WIDTH-1:0]   acc [K];
    logic [DATA_WIDTH-1:0]         res [K];
    logic signed [63:0]            wide;
    logic signed [63:0]            rs;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_grp = (g_q == BW'(G - 1));
    assign lane_clr = accept || (state_q == S_WB);
    assign lane_en  = ((state_q == S_MAC) && (i_q != '0))
                   || (state_q == S_DRAIN);

    // Read data lags the address by one cycle, so pair it with x[i-1].
    assign xi   = (i_q == '0) ? '0 : i_q - IW'(1);
    assign x_op = x_q[xi*DATA_WIDTH +: DATA_WIDTH];

    for (genvar k = 0; k < K; k++) begin : g_lane
        fc_mac_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr_i(lane_clr),
            .en_i (lane_en),
            .a_i  (x_op),
            .b_i  (w_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .acc_o(acc[k])
        );
    end

    always_comb begin
        wide = '0;
        rs   = '0;
        for (int k = 0; k < K; k++) begin
            wide = 64'(acc[k])
                 + (64'($signed(bias_q[k*DATA_WIDTH +: DATA_WIDTH]))
                    <<< FRAC_BITS);
            rs = round_sat(wide, FRAC_BITS, DATA_WIDTH);
`ifdef FC_RELU_EN
            if (rs < 0) begin
                rs = '0;
            end
`endif
            res[k] = rs[DATA_WIDTH-1:0];
        end
    end

    // Lanes past OUT_DIM in the final group are dropped.
    always_comb begin
        out_d = out_q;
        if (state_q == S_WB) begin
            for (int k = 0; k < K; k++) begin
                if (int'(g_q) * K + k < OUT_DIM) begin
                    out_d[(int'(g_q)*K + k)*DATA_WIDTH +: DATA_WIDTH] = res[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            g_q      <= '0;
            i_q      <= '0;
            w_addr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= '0;
            bias_q   <= '0;
            out_q    <= '0;
        end else begin
            out_q <= out_d;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q      <= in_vector;
                        g_q      <= '0;
                        i_q      <= '0;
                        w_addr_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_MAC;
                    end
                end
                S_MAC: begin
                    i_q <= i_q + IW'(1);
                    if (i_q == IW'(IN_DIM - 1)) begin
                        state_q <= S_DRAIN;
                    end else begin
                        w_addr_q <= w_addr_q + AW'(1);
                    end
                end
                S_DRAIN: begin
                    bias_q  <= b_data;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (last_grp) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        g_q      <= g_q + BW'(1);
                        i_q      <= '0;
                        w_addr_q <= w_addr_q + AW'(1);
                        state_q  <= S_MAC;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign w_addr     = w_addr_q;
    assign b_addr     = g_q;
    assign out_vector = out_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb_fc_layer_engine: directed vectors for a 4-in, 6-out, 4-lane engine
// with a 1-cycle-latency weight/bias memory model.
module tb_fc_layer_engine;
    import fc_pkg::*;

    localparam int DW  = 16;
    localparam int ACW = 40;
    localparam int FB  = 12;
    localparam int IN  = 4;
    localparam int OUT = 6;
    localparam int KK  = 4;
    localparam int G   = 2;
    localparam int WA  = 3;
    localparam int BA  = 1;
    localparam int LAT = 13;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] xr;
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] e;
        logic [15:0] er;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [IN*DW-1:0]  in_vector = '0;
    logic [WA-1:0]     w_addr;
    logic [KK*DW-1:0]  w_data = '0;
    logic [BA-1:0]     b_addr;
    logic [KK*DW-1:0]  b_data = '0;
    logic [OUT*DW-1:0] out_vector;
    logic              busy;
    logic              done;

    logic [KK*DW-1:0]  wmem [G*IN];
    logic [KK*DW-1:0]  bmem [G];

    int checks   = 0;
    int failures = 0;

    vec_t vecs [7];

    fc_layer_engine #(
        .DATA_WIDTH(DW),
        .ACC_WIDTH (ACW),
        .FRAC_BITS (FB),
        .IN_DIM    (IN),
        .OUT_DIM   (OUT),
        .K         (KK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_vector (in_vector),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .out_vector(out_vector),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data <= wmem[w_addr];
        b_data <= bmem[b_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic load_uniform(input vec_t v);
        for (int i = 0; i < IN; i++)
            in_vector[i*DW +: DW] = (i == 0) ? v.x0 : v.xr;
        for (int a = 0; a < G*IN; a++) wmem[a] = {KK{v.w}};
        for (int g = 0; g < G; g++) bmem[g] = {KK{v.b}};
    endtask

    task automatic load_distinct();
        int n;
        for (int i = 0; i < IN; i++) in_vector[i*DW +: DW] = 16'h1000;
        for (int g = 0; g < G; g++) begin
            for (int k = 0; k < KK; k++) begin
                n = g*KK + k;
                bmem[g][k*DW +: DW] = 16'(n * 256);
                for (int i = 0; i < IN; i++)
                    wmem[g*IN + i][k*DW +: DW] = 16'((n + 1) * 1024);
            end
        end
    endtask

    // Start in cycle 0; cycle n is sampled at its negedge.
    task automatic run_pass(input int glitch, input bit chk_addr);
        int lat;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (chk_addr) begin
                if (lat >= 1 && lat <= 4)
                    chk($sformatf("w_addr_c%0d", lat), 64'(w_addr), 64'(lat - 1));
                if (lat >= 7 && lat <= 10)
                    chk($sformatf("w_addr_c%0d", lat), 64'(w_addr), 64'(lat - 3));
                if (lat == 4) chk("b_addr_g0", 64'(b_addr), 64'd0);
                if (lat == 10) chk("b_addr_g1", 64'(b_addr), 64'd1);
                if (lat == 1 || lat == 12)
                    chk($sformatf("busy_c%0d", lat), 64'(busy), 64'd1);
            end
            start = (lat == glitch);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("latency", 64'(lat), 64'(LAT));
        chk("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    task automatic chk_distinct(input string tag);
        logic [15:0] e;
        for (int n = 0; n < OUT; n++) begin
            e = 16'(((n + 1) << 12) + (n << 8));
            chk($sformatf("%s_out%0d", tag, n),
                64'(out_vector[n*DW +: DW]), 64'(e));
        end
    endtask

    initial begin
        int cnt;
        logic [15:0] e;

        vecs[0] = '{16'h0800, 16'h0800, 16'h1000, 16'h0000, 16'h2000, 16'h2000};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000,
                    FC_QMAX, FC_QMAX};
        vecs[2] = '{16'h8001, 16'h8001, 16'h7FFF, 16'h0000,
                    FC_QMIN, 16'h0000};
        vecs[3] = '{16'h0001, 16'h0000, 16'h0800, 16'h0000, 16'h0001, 16'h0001};
        vecs[4] = '{16'h0001, 16'h0000, 16'h07FF, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 16'hF000, 16'hF000, 16'h0000};
        vecs[6] = '{16'h1000, 16'h0800, 16'hF000, 16'h0400, 16'hDC00, 16'h0000};

        for (int a = 0; a < G*IN; a++) wmem[a] = '0;
        for (int g = 0; g < G; g++) bmem[g] = '0;

        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_b_addr", 64'(b_addr), 64'd0);
        chk("rst_out_zero", 64'(out_vector == '0), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            load_uniform(vecs[v]);
            run_pass(0, v == 0);
`ifdef FC_RELU_EN
            e = vecs[v].er;
`else
            e = vecs[v].e;
`endif
            for (int n = 0; n < OUT; n++)
                chk($sformatf("vec%0d_out%0d", v, n),
                    64'(out_vector[n*DW +: DW]), 64'(e));
        end

        load_distinct();
        run_pass(0, 1'b0);
        chk_distinct("distinct");

        load_uniform(vecs[0]);
        run_pass(2, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("glitch_no_extra_done", 64'(cnt), 64'd0);

        load_distinct();
        run_pass(0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out_zero", 64'(out_vector == '0), 64'd1);
        chk("midrst_w_addr", 64'(w_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("midrst_quiet", 64'(cnt), 64'd0);
        run_pass(0, 1'b1);
        chk_distinct("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
